// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high (or low) time of i_pwm in
// prescaled clock ticks, exposed on the peripheral register bus with a level interrupt.
module pwm_capture #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    input  logic        i_pwm,
    output logic        intr_o
);

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_DIVISOR = 8'h04;
    localparam logic [7:0] ADDR_PERIOD  = 8'h08;
    localparam logic [7:0] ADDR_HIGH    = 8'h0C;
    localparam logic [7:0] ADDR_STATUS  = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH_PH,
        LOW_PH
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] divisor_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] hi_lat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_sum;
    logic [CNT_W-1:0] psc_q;
    logic             valid_q;
    logic             ovf_q;
    logic             intr_q;
    logic             sync1_q, sync2_q, lvl_q;
    logic             lvl, rise, fall, tick, cnt_max;
    logic             wr, wr_ctrl, wr_div, wr_status;
    logic             cnt_clr, cnt_inc, psc_clr, hi_load, cap_load, ovf_set, en_clr, busy;
    logic             ctrl_en, ctrl_irq, ctrl_cont, ctrl_inv;
    logic             unused_bits;

    assign unused_bits = ^{be_i, wdata_i};

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_irq  = ctrl_q[1];
    assign ctrl_cont = ctrl_q[2];
    assign ctrl_inv  = ctrl_q[3];

    assign wr        = we_i & ~re_i;
    assign wr_ctrl   = wr && (addr_i == ADDR_CTRL);
    assign wr_div    = wr && (addr_i == ADDR_DIVISOR);
    assign wr_status = wr && (addr_i == ADDR_STATUS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            sync1_q <= i_pwm;
            sync2_q <= sync1_q;
            lvl_q   <= lvl;
        end
    end

    assign lvl  = sync2_q ^ ctrl_inv;
    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    assign tick = (psc_q == divisor_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_q <= '0;
        end else if (psc_clr || rise || tick) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + 1'b1;
        end
    end

    // Latched values include a tick landing on the edge cycle itself, so a
    // period of N ticks reads back as N rather than N-1.
    assign cnt_sum = cnt_q + CNT_W'(tick);
    assign cnt_max = (cnt_q == '1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ctrl_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = HIGH_PH;
                HIGH_PH: begin
                    if (tick && cnt_max) state_d = ARM;
                    else if (fall)       state_d = LOW_PH;
                end
                LOW_PH: begin
                    if (tick && cnt_max) state_d = ARM;
                    else if (rise)       state_d = ctrl_cont ? HIGH_PH : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        psc_clr  = 1'b0;
        hi_load  = 1'b0;
        cap_load = 1'b0;
        ovf_set  = 1'b0;
        en_clr   = 1'b0;
        busy     = (state_q != IDLE);
        if (!ctrl_en) begin
            cnt_clr = 1'b1;
            psc_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    psc_clr = 1'b1;
                end
                ARM: cnt_clr = 1'b1;
                HIGH_PH: begin
                    if (tick && cnt_max) begin
                        ovf_set = 1'b1;
                    end else begin
                        cnt_inc = tick;
                        hi_load = fall;
                    end
                end
                LOW_PH: begin
                    if (tick && cnt_max) begin
                        ovf_set = 1'b1;
                    end else if (rise) begin
                        cap_load = 1'b1;
                        cnt_clr  = 1'b1;
                        en_clr   = ~ctrl_cont;
                    end else begin
                        cnt_inc = tick;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_sum;
            if (hi_load) hi_lat_q <= cnt_sum;
            if (cap_load) begin
                period_q <= cnt_sum;
                high_q   <= hi_lat_q;
            end
        end
    end

    // Hardware en clear takes priority over a same-cycle software write.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) ctrl_d = wdata_i[3:0];
        if (en_clr)  ctrl_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            divisor_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            if (wr_div) divisor_q <= wdata_i[CNT_W-1:0];
            valid_q <= cap_load | (valid_q & ~(wr_status & wdata_i[0]));
            ovf_q   <= ovf_set  | (ovf_q   & ~(wr_status & wdata_i[1]));
            intr_q  <= ctrl_irq & valid_q;
        end
    end

    assign intr_o = intr_q;

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            ADDR_CTRL:    rdata_o[3:0]       = ctrl_q;
            ADDR_DIVISOR: rdata_o[CNT_W-1:0] = divisor_q;
            ADDR_PERIOD:  rdata_o[CNT_W-1:0] = period_q;
            ADDR_HIGH:    rdata_o[CNT_W-1:0] = high_q;
            ADDR_STATUS:  rdata_o[2:0]       = {busy, ovf_q, valid_q};
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected read/irq values,
// a negedge monitor pops and compares whenever a read or irq probe is presented.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic [31:0] rdata;
    logic        pwm = 1'b0;
    logic        intr;
    logic        probe = 1'b0;

    int          pwm_per = 100;
    int          pwm_hi = 30;
    bit          pwm_on = 1'b0;
    bit          pwm_single = 1'b0;

    typedef struct {
        bit          is_intr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] act;
    int          tests = 0;
    int          fails = 0;

    pwm_capture #(.CNT_W(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .re_i    (re),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .rdata_o (rdata),
        .i_pwm   (pwm),
        .intr_o  (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (pwm_single) begin
            pwm_single = 1'b0;
            pwm = 1'b1;
            repeat (10) @(posedge clk);
            #1 pwm = 1'b0;
        end else if (pwm_on) begin
            int p, h;
            p = pwm_per;
            h = pwm_hi;
            pwm = 1'b1;
            repeat (h) @(posedge clk);
            #1 pwm = 1'b0;
            repeat (p - h - 1) @(posedge clk);
        end else begin
            pwm = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (re || probe) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample: got 0x%08h required nothing queued", re ? rdata : {31'b0, intr});
            end else begin
                e = q.pop_front();
                act = e.is_intr ? {31'b0, intr} : rdata;
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        addr = a;
        wdata = d;
        we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] x, input string n);
        @(posedge clk);
        #1;
        q.push_back('{1'b0, x, n});
        addr = a;
        re = 1'b1;
        @(posedge clk);
        #1 re = 1'b0;
    endtask

    task automatic chk_intr(input logic x, input string n);
        @(posedge clk);
        #1;
        q.push_back('{1'b1, {31'b0, x}, n});
        probe = 1'b1;
        @(posedge clk);
        #1 probe = 1'b0;
    endtask

    task automatic wait_level(input logic v);
        int k;
        k = 0;
        while (pwm !== v && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            tests++;
            fails++;
            $display("FAIL wait_pin: got %0b required %0b", pwm, v);
        end
    endtask

    initial begin
        // reset state, read combinationally while rst_n is low
        cycles(3);
        rd(8'h00, 32'h0, "reset_ctrl");
        rd(8'h10, 32'h0, "reset_status");
        rd(8'h08, 32'h0, "reset_period");
        chk_intr(1'b0, "reset_intr");
        rst_n = 1'b1;
        cycles(2);

        // 1: continuous, divisor 0, 100/30 then 80/20
        wr(8'h04, 32'd0);
        pwm_per = 100; pwm_hi = 30; pwm_on = 1'b1;
        wr(8'h00, 32'h5);
        cycles(300);
        rd(8'h08, 32'd100, "t1_period");
        rd(8'h0C, 32'd30,  "t1_high");
        rd(8'h10, 32'h5,   "t1_status");
        chk_intr(1'b0, "t1_intr_masked");
        rd(8'h20, 32'h0,   "unmapped_addr");
        pwm_per = 80; pwm_hi = 20;
        cycles(300);
        rd(8'h08, 32'd80, "t1_period_relatch");
        rd(8'h0C, 32'd20, "t1_high_relatch");

        // 2: divisor 3, 400/100
        wr(8'h00, 32'h0);
        rd(8'h10, 32'h1, "t2_status_disabled");
        wr(8'h10, 32'h1);
        wr(8'h04, 32'd3);
        pwm_per = 400; pwm_hi = 100;
        cycles(100);
        wr(8'h00, 32'h5);
        cycles(1300);
        rd(8'h08, 32'd100, "t2_period");
        rd(8'h0C, 32'd25,  "t2_high");
        rd(8'h04, 32'd3,   "t2_divisor");

        // 3: one-shot with interrupt
        wr(8'h00, 32'h0);
        wr(8'h04, 32'd0);
        wr(8'h10, 32'h3);
        pwm_per = 60; pwm_hi = 20;
        cycles(500);
        wr(8'h00, 32'h3);
        cycles(300);
        rd(8'h08, 32'd60, "t3_period");
        rd(8'h0C, 32'd20, "t3_high");
        rd(8'h00, 32'h2,  "t3_ctrl_en_cleared");
        rd(8'h10, 32'h1,  "t3_status");
        chk_intr(1'b1, "t3_intr_set");
        pwm_per = 50; pwm_hi = 10;
        cycles(200);
        rd(8'h08, 32'd60, "t3_period_held");
        wr(8'h10, 32'h1);
        chk_intr(1'b0, "t3_intr_cleared");
        rd(8'h10, 32'h0, "t3_status_cleared");

        // 4: overflow with pin held low after one rise
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h3);
        pwm_on = 1'b0;
        cycles(500);
        wr(8'h00, 32'h1);
        cycles(5);
        pwm_single = 1'b1;
        cycles(65000);
        rd(8'h10, 32'h4, "t4_status_before_ovf");
        cycles(700);
        rd(8'h10, 32'h6, "t4_status_ovf");
        rd(8'h08, 32'd60, "t4_period_unchanged");
        wr(8'h10, 32'h2);
        rd(8'h10, 32'h4, "t4_ovf_cleared");

        // 5: W1C colliding with capture; invert
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h3);
        pwm_per = 100; pwm_hi = 30; pwm_on = 1'b1;
        cycles(100);
        wr(8'h00, 32'h5);
        cycles(300);
        wait_level(1'b0);
        wait_level(1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        addr = 8'h10;
        wdata = 32'h1;
        we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        rd(8'h10, 32'h5, "t5_valid_set_wins");
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h3);
        wr(8'h00, 32'hD);
        cycles(400);
        rd(8'h0C, 32'd70,  "t5_invert_low_time");
        rd(8'h08, 32'd100, "t5_invert_period");
        rd(8'h00, 32'hD,   "t5_ctrl");

        // 6: reset in HIGH_PH, then first period discarded
        wr(8'h00, 32'h0);
        wr(8'h10, 32'h3);
        wr(8'h04, 32'd1);
        wr(8'h00, 32'h7);
        cycles(400);
        rd(8'h08, 32'd50, "t6_period_div1");
        rd(8'h0C, 32'd15, "t6_high_div1");
        chk_intr(1'b1, "t6_intr_before_reset");
        wait_level(1'b0);
        wait_level(1'b1);
        cycles(10);
        #1 rst_n = 1'b0;
        rd(8'h00, 32'h0, "t6_rst_ctrl");
        rd(8'h04, 32'h0, "t6_rst_divisor");
        rd(8'h08, 32'h0, "t6_rst_period");
        rd(8'h0C, 32'h0, "t6_rst_high");
        rd(8'h10, 32'h0, "t6_rst_status");
        chk_intr(1'b0, "t6_rst_intr");
        rst_n = 1'b1;
        wait_level(1'b1);
        wait_level(1'b0);
        wr(8'h00, 32'h5);
        cycles(100);
        rd(8'h10, 32'h4, "t6_first_period_discarded");
        cycles(150);
        rd(8'h08, 32'd100, "t6_period_after_reset");
        rd(8'h0C, 32'd30,  "t6_high_after_reset");
        rd(8'h10, 32'h5,   "t6_status_after_reset");

        cycles(5);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
